// File: rtl/cpu_branch_unit_pkg.sv
// Shared CPU definitions: jump/call/return mode encodings for the branch unit.
package cpu_branch_unit_pkg;

  localparam int unsigned JMP_MODE_W = 3;

  typedef enum logic [JMP_MODE_W-1:0] {
    MODE_NOP       = 3'b000,
    MODE_JMP_ABS   = 3'b001,
    MODE_JMP_BASE  = 3'b010,
    MODE_JMP_PC    = 3'b011,
    MODE_CALL_ABS  = 3'b100,
    MODE_CALL_BASE = 3'b101,
    MODE_RET       = 3'b110,
    MODE_RSVD      = 3'b111
  } jmp_mode_e;

endpackage

// File: rtl/cpu_branch_unit_alu_add.sv
// Plain modulo-2^WIDTH adder shared by the CPU datapath; carry out is discarded.
module cpu_branch_unit_alu_add #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum
);

  assign sum = a + b;

endmodule

// File: rtl/cpu_branch_unit.sv
// Branch unit: next-PC selection for jumps/calls/returns, base register and return stack.
module cpu_branch_unit
  import cpu_branch_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [JMP_MODE_W-1:0]  jmp_mode,
  input  logic                   cond,
  input  logic [WIDTH-1:0]       pc_in,
  input  logic [WIDTH-1:0]       offset,
  input  logic                   base_ld,
  input  logic [WIDTH-1:0]       base_data,
  input  logic                   clr_err,
  output logic [WIDTH-1:0]       address_out,
  output logic                   taken,
  output logic [$clog2(DEPTH):0] sp,
  output logic                   stack_ovf,
  output logic                   stack_unf
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned SP_W  = PTR_W + 1;

  logic [WIDTH-1:0] base_q;
  logic [WIDTH-1:0] stack_q [DEPTH];

  logic [WIDTH-1:0] pc_plus1;
  logic [WIDTH-1:0] base_rel;
  logic [WIDTH-1:0] pc_rel;

  logic             do_push;
  logic             do_pop;
  logic             ovf_evt;
  logic             unf_evt;
  logic             stack_full;
  logic             stack_empty;
  logic [PTR_W-1:0] top_idx;
  logic [PTR_W-1:0] push_idx;

  cpu_branch_unit_alu_add #(.WIDTH(WIDTH)) u_add_seq (
    .a   (pc_in),
    .b   (WIDTH'(1)),
    .sum (pc_plus1)
  );

  cpu_branch_unit_alu_add #(.WIDTH(WIDTH)) u_add_base (
    .a   (base_q),
    .b   (offset),
    .sum (base_rel)
  );

  cpu_branch_unit_alu_add #(.WIDTH(WIDTH)) u_add_pc (
    .a   (pc_in),
    .b   (offset),
    .sum (pc_rel)
  );

  assign stack_full  = (sp == SP_W'(DEPTH));
  assign stack_empty = (sp == '0);
  assign top_idx     = PTR_W'(sp - SP_W'(1));
  assign push_idx    = PTR_W'(sp);

  // Next-PC selection and stack/error events for this cycle
  always_comb begin
    address_out = pc_plus1;
    taken       = 1'b0;
    do_push     = 1'b0;
    do_pop      = 1'b0;
    ovf_evt     = 1'b0;
    unf_evt     = 1'b0;
    if (en) begin
      case (jmp_mode_e'(jmp_mode))
        MODE_JMP_ABS: if (cond) begin
          address_out = offset;
          taken       = 1'b1;
        end
        MODE_JMP_BASE: if (cond) begin
          address_out = base_rel;
          taken       = 1'b1;
        end
        MODE_JMP_PC: if (cond) begin
          address_out = pc_rel;
          taken       = 1'b1;
        end
        MODE_CALL_ABS, MODE_CALL_BASE: begin
          address_out = (jmp_mode_e'(jmp_mode) == MODE_CALL_ABS) ? offset : base_rel;
          taken       = 1'b1;
          ovf_evt     = stack_full;
          do_push     = !stack_full;
        end
        MODE_RET: begin
          // Empty stack: fall through rather than expose a stale entry
          if (stack_empty) begin
            unf_evt = 1'b1;
          end else begin
            address_out = stack_q[top_idx];
            taken       = 1'b1;
            do_pop      = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp        <= '0;
      base_q    <= '0;
      stack_ovf <= 1'b0;
      stack_unf <= 1'b0;
    end else begin
      if (do_push) sp <= sp + SP_W'(1);
      else if (do_pop) sp <= sp - SP_W'(1);
      if (base_ld) base_q <= base_data;
      // A new error event outranks a clear in the same cycle
      if (ovf_evt) stack_ovf <= 1'b1;
      else if (clr_err) stack_ovf <= 1'b0;
      if (unf_evt) stack_unf <= 1'b1;
      else if (clr_err) stack_unf <= 1'b0;
    end
  end

  // Return-address storage; contents above sp are don't-care, so no reset
  always_ff @(posedge clk) begin
    if (do_push) stack_q[push_idx] <= pc_plus1;
  end

endmodule

// File: tb/tb_cpu_branch_unit.sv
// Directed self-checking bench for cpu_branch_unit (WIDTH=8, DEPTH=4).
module tb_cpu_branch_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [2:0] jmp_mode;
  logic       cond;
  logic [7:0] pc_in;
  logic [7:0] offset;
  logic       base_ld;
  logic [7:0] base_data;
  logic       clr_err;
  logic [7:0] address_out;
  logic       taken;
  logic [2:0] sp;
  logic       stack_ovf;
  logic       stack_unf;

  int n_checks = 0;
  int n_pass   = 0;

  cpu_branch_unit #(.WIDTH(8), .DEPTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .jmp_mode    (jmp_mode),
    .cond        (cond),
    .pc_in       (pc_in),
    .offset      (offset),
    .base_ld     (base_ld),
    .base_data   (base_data),
    .clr_err     (clr_err),
    .address_out (address_out),
    .taken       (taken),
    .sp          (sp),
    .stack_ovf   (stack_ovf),
    .stack_unf   (stack_unf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic drive(input logic e, input logic [2:0] m, input logic c,
                       input logic [7:0] pc, input logic [7:0] off);
    en = e; jmp_mode = m; cond = c; pc_in = pc; offset = off;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_next(input string tag, input logic [7:0] addr, input logic tk);
    check({tag, "_addr"}, 32'(address_out), 32'(addr));
    check({tag, "_taken"}, 32'(taken), 32'(tk));
  endtask

  initial begin
    rst = 1'b1; base_ld = 1'b0; base_data = '0; clr_err = 1'b0;
    drive(1'b0, 3'b000, 1'b0, 8'h00, 8'h00);
    check("rst_sp", 32'(sp), 0);
    check("rst_ovf", 32'(stack_ovf), 0);
    check("rst_unf", 32'(stack_unf), 0);
    check_next("rst_nop", 8'h01, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Base-relative jump after base load
    base_ld = 1'b1; base_data = 8'h40;
    drive(1'b1, 3'b000, 1'b0, 8'h00, 8'h00);
    step();
    base_ld = 1'b0;
    drive(1'b1, 3'b010, 1'b1, 8'h00, 8'h05);
    check_next("base_rel", 8'h45, 1'b1);
    drive(1'b1, 3'b010, 1'b0, 8'h00, 8'h05);
    check_next("base_rel_nc", 8'h01, 1'b0);
    drive(1'b1, 3'b001, 1'b1, 8'h30, 8'h77);
    check_next("abs", 8'h77, 1'b1);
    drive(1'b1, 3'b011, 1'b1, 8'hFE, 8'h04);
    check_next("pc_rel_wrap", 8'h02, 1'b1);
    drive(1'b1, 3'b011, 1'b0, 8'hFE, 8'h04);
    check_next("pc_rel_nc", 8'hFF, 1'b0);
    drive(1'b1, 3'b011, 1'b1, 8'h10, 8'hFC);
    check_next("pc_rel_neg", 8'h0C, 1'b1);
    drive(1'b0, 3'b001, 1'b1, 8'h30, 8'h77);
    check_next("en_off", 8'h31, 1'b0);
    drive(1'b1, 3'b111, 1'b1, 8'h30, 8'h77);
    check_next("reserved", 8'h31, 1'b0);

    // Five calls: the fifth overflows but still jumps
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, 3'b100, 1'b0, 8'(i * 16), 8'h99);
      check_next($sformatf("call%0d", i), 8'h99, 1'b1);
      step();
      check($sformatf("call%0d_sp", i), 32'(sp), (i > 4) ? 4 : i);
      check($sformatf("call%0d_ovf", i), 32'(stack_ovf), (i > 4) ? 1 : 0);
    end
    for (int i = 4; i >= 1; i--) begin
      drive(1'b1, 3'b110, 1'b0, 8'hC0, 8'h00);
      check_next($sformatf("ret%0d", i), 8'(i * 16 + 1), 1'b1);
      step();
      check($sformatf("ret%0d_sp", i), 32'(sp), i - 1);
    end
    check("ovf_sticky", 32'(stack_ovf), 1);
    clr_err = 1'b1;
    drive(1'b1, 3'b000, 1'b0, 8'h00, 8'h00);
    step();
    clr_err = 1'b0;
    check("ovf_clr", 32'(stack_ovf), 0);

    // Underflow, set-wins over clear, then clear
    drive(1'b1, 3'b110, 1'b0, 8'h80, 8'h00);
    check_next("unf", 8'h81, 1'b0);
    step();
    check("unf_flag", 32'(stack_unf), 1);
    check("unf_sp", 32'(sp), 0);
    clr_err = 1'b1;
    step();
    check("unf_set_wins", 32'(stack_unf), 1);
    drive(1'b1, 3'b000, 1'b0, 8'h80, 8'h00);
    step();
    clr_err = 1'b0;
    check("unf_clr", 32'(stack_unf), 0);

    // Base load coincident with base-relative call uses the old base
    base_ld = 1'b1; base_data = 8'h10;
    drive(1'b1, 3'b000, 1'b0, 8'h00, 8'h00);
    step();
    base_data = 8'h20;
    drive(1'b1, 3'b101, 1'b0, 8'h60, 8'h03);
    check_next("call_base_old", 8'h13, 1'b1);
    step();
    base_ld = 1'b0;
    check("call_base_sp", 32'(sp), 1);
    drive(1'b1, 3'b010, 1'b1, 8'h70, 8'h03);
    check_next("base_new", 8'h23, 1'b1);
    drive(1'b1, 3'b110, 1'b0, 8'h70, 8'h00);
    check_next("ret_base_call", 8'h61, 1'b1);
    step();

    // Async reset mid-cycle aborts a pending push
    drive(1'b1, 3'b110, 1'b0, 8'h00, 8'h00);
    step();
    drive(1'b1, 3'b100, 1'b0, 8'h10, 8'h50);
    step();
    drive(1'b1, 3'b100, 1'b0, 8'h20, 8'h50);
    step();
    check("pre_rst_sp", 32'(sp), 2);
    check("pre_rst_unf", 32'(stack_unf), 1);
    #1 rst = 1'b1;
    #1;
    check("async_rst_sp", 32'(sp), 0);
    check("async_rst_unf", 32'(stack_unf), 0);
    check("async_rst_ovf", 32'(stack_ovf), 0);
    step();
    check("rst_hold_sp", 32'(sp), 0);
    rst = 1'b0;
    drive(1'b0, 3'b100, 1'b0, 8'h40, 8'h50);
    check_next("en_off_call", 8'h41, 1'b0);
    step();
    check("en_off_call_sp", 32'(sp), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/cpu_branch_unit.md
CPU_BRANCH_UNIT -- requirements
Module: cpu_branch_unit

Interface
REQ-001 Parameter WIDTH, default 8: address/data width in bits.
REQ-002 Parameter DEPTH, default 4: return-stack entries; power of two, >= 2.
REQ-003 CLK  input  1: single clock; all state updates on rising edge.
REQ-004 RST  input  1: reset, asynchronous, active-high.
REQ-005 EN  input  1: instruction valid; when 0, the cycle is treated as NOP with no state change.
REQ-006 JMP_MODE  input  3: 000 NOP, 001 JMP abs, 010 JMP base-rel, 011 JMP PC-rel, 100 CALL abs, 101 CALL base-rel, 110 RET, 111 reserved (= NOP).
REQ-007 COND  input  1: condition for modes 001-011; ignored by other modes.
REQ-008 PC_IN  input  WIDTH: current program counter.
REQ-009 OFFSET  input  WIDTH: absolute target or two's-complement displacement.
REQ-010 BASE_LD  input  1: load base register from BASE_DATA at the next edge.
REQ-011 BASE_DATA  input  WIDTH: new base address.
REQ-012 CLR_ERR  input  1: synchronous clear of sticky error flags.
REQ-013 ADDRESS_OUT  output  WIDTH: next PC, combinational.
REQ-014 TAKEN  output  1: 1 when ADDRESS_OUT is not PC_IN+1 by fall-through.
REQ-015 SP  output  $clog2(DEPTH)+1: current stack occupancy, 0..DEPTH.
REQ-016 STACK_OVF  output  1: sticky, CALL attempted when full.
REQ-017 STACK_UNF  output  1: sticky, RET attempted when empty.

Function
REQ-018 All address arithmetic SHALL wrap modulo 2^WIDTH; carries discarded.
REQ-019 NOP/reserved/EN=0: ADDRESS_OUT = PC_IN+1, TAKEN = 0.
REQ-020 001: ADDRESS_OUT = OFFSET; 010: BASE+OFFSET; 011: PC_IN+OFFSET; each only if COND=1, else PC_IN+1 with TAKEN=0.
REQ-021 100/101: target as 001/010 unconditionally, TAKEN=1; PC_IN+1 pushed at the edge, SP increments.
REQ-022 110: ADDRESS_OUT = top-of-stack entry, TAKEN=1; entry popped at the edge, SP decrements.
REQ-023 CALL with SP=DEPTH: jump still taken, push suppressed, SP unchanged, STACK_OVF set at the edge.
REQ-024 RET with SP=0: ADDRESS_OUT = PC_IN+1, TAKEN=0, SP unchanged, STACK_UNF set at the edge.
REQ-025 Output latency zero: ADDRESS_OUT/TAKEN purely combinational from inputs and current state.
REQ-026 BASE_LD with a base-relative mode in the same cycle: jump uses the old base; new base visible next cycle.
REQ-027 BASE_LD SHALL act regardless of EN.
REQ-028 CLR_ERR together with a new error event in the same cycle: the flag is set (set wins).
REQ-029 Stack entries not addressed by SP are don't-care; no read of stale entries is visible at outputs.

Reset
REQ-030 On RST: SP=0, base register=0, STACK_OVF=0, STACK_UNF=0; stack contents need not be cleared.
REQ-031 Reset asserted mid-operation SHALL abort any pending push/pop/base load; outputs reflect reset state immediately.

Structure
REQ-032 JMP_MODE encodings SHALL be named constants in the shared CPU package.
REQ-033 Target and return-address adders SHALL reuse the existing alu_add sub-module; the stack is an internal register array, no further sub-modules.

Verification (WIDTH=8, DEPTH=4)
REQ-034 Reset, BASE_LD=1 BASE_DATA=0x40, then mode 010 OFFSET=0x05 COND=1 -> ADDRESS_OUT=0x45, TAKEN=1.
REQ-035 PC_IN=0xFE, mode 011 OFFSET=0x04 COND=1 -> ADDRESS_OUT=0x02 (wrap); same with COND=0 -> 0xFF, TAKEN=0.
REQ-036 Five CALLs at PC_IN=0x10,0x20,0x30,0x40,0x50 -> SP=4, STACK_OVF=1; four RETs -> ADDRESS_OUT 0x41,0x31,0x21,0x11.
REQ-037 RET with SP=0 at PC_IN=0x80 -> ADDRESS_OUT=0x81, TAKEN=0, STACK_UNF=1; CLR_ERR -> STACK_UNF=0 next cycle.
REQ-038 BASE_LD=1 BASE_DATA=0x20 with mode 101 OFFSET=0x03 while base=0x10 -> ADDRESS_OUT=0x13; next cycle 010 OFFSET=0x03 -> 0x23.
REQ-039 RST asserted between edges after two CALLs -> SP=0 and flags 0 immediately; EN=0 CALL afterwards -> SP stays 0.
